// File: rtl/uart_rx_fsm.sv
// UART receiver FSM: samples rx at mid-bit after an upstream start-edge pulse,
// shifts data LSB-first, optionally checks parity, and reports each completed frame.
module uart_rx_fsm #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   input  logic                 start_edge,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
   localparam logic          ODD      = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        baud_q, baud_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_err_q, par_err_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 parity_err_q, parity_err_d;
   logic                 frame_err_q, frame_err_d;
   logic                 baud_wrap;

   assign baud_wrap = (baud_q == FULL_M1);

   always_comb begin
      state_d      = state_q;
      baud_d       = baud_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      par_err_d    = par_err_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;

      case (state_q)
         S_IDLE: begin
            if (start_edge) begin
               state_d = S_START;
               baud_d  = '0;
            end
         end
         S_START: begin
            // Half a bit period lands the start-bit check at mid-bit; all later
            // samples are a whole period apart and therefore also mid-bit.
            if (baud_q == HALF_M1) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = rx ? S_IDLE : S_DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_DATA: begin
            if (baud_wrap) begin
               baud_d  = '0;
               shift_d = {rx, shift_q[DATA_BITS-1:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == LAST_BIT) begin
                  state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_PARITY: begin
            if (baud_wrap) begin
               baud_d    = '0;
               par_err_d = (^shift_q) ^ rx ^ ODD;
               state_d   = S_STOP;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_STOP: begin
            if (baud_wrap) begin
               baud_d       = '0;
               state_d      = S_IDLE;
               rx_data_d    = shift_q;
               frame_err_d  = ~rx;
               parity_err_d = (PARITY_EN != 0) ? par_err_q : 1'b0;
               rx_valid_d   = 1'b1;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            baud_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         baud_q       <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         par_err_q    <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         baud_q       <= baud_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         par_err_q    <= par_err_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: instance 0 without parity, instance 1 with even parity;
// frames are built bit-by-bit and expected results derived from the frame contents.
module tb_uart_rx_fsm;

   localparam int CPB = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  rx_l;
   logic [1:0]  se_l;
   logic [15:0] data_w;
   logic [1:0]  valid_w, perr_w, ferr_w, busy_w;

   int          checks   = 0;
   int          failures = 0;
   int          vcnt [2] = '{0, 0};
   int          vexp [2] = '{0, 0};
   logic [7:0]  exp_data [2];
   logic        exp_pe [2];
   logic        exp_fe [2];

   always #5 clk = ~clk;

   uart_rx_fsm #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
      .clk(clk), .rst(rst), .rx(rx_l[0]), .start_edge(se_l[0]),
      .rx_data(data_w[7:0]), .rx_valid(valid_w[0]), .parity_err(perr_w[0]),
      .frame_err(ferr_w[0]), .busy(busy_w[0])
   );

   uart_rx_fsm #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
      .clk(clk), .rst(rst), .rx(rx_l[1]), .start_edge(se_l[1]),
      .rx_data(data_w[15:8]), .rx_valid(valid_w[1]), .parity_err(perr_w[1]),
      .frame_err(ferr_w[1]), .busy(busy_w[1])
   );

   // Count every rx_valid pulse seen on each instance.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (valid_w[i]) vcnt[i] <= vcnt[i] + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_out(input int d);
      chk($sformatf("dut%0d_rx_data", d), data_w[d*8 +: 8], exp_data[d]);
      chk($sformatf("dut%0d_parity_err", d), perr_w[d], exp_pe[d]);
      chk($sformatf("dut%0d_frame_err", d), ferr_w[d], exp_fe[d]);
      chk($sformatf("dut%0d_valid_count", d), vcnt[d], vexp[d]);
      chk($sformatf("dut%0d_busy_idle", d), busy_w[d], 0);
   endtask

   task automatic clear_expect();
      for (int i = 0; i < 2; i++) begin
         exp_data[i] = 8'h00;
         exp_pe[i]   = 1'b0;
         exp_fe[i]   = 1'b0;
      end
   endtask

   // Drive one frame; optional start_edge injection, shortened stop bit, or reset mid-data.
   task automatic send_frame(input int d, input logic [7:0] data, input logic par,
                             input logic stp, input bit inject, input int stop_len,
                             input int rst_bit);
      logic bits[$];
      int   len;
      int   last;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(data[i]);
      if (d == 1) bits.push_back(par);
      bits.push_back(stp);
      last = bits.size() - 1;
      for (int b = 0; b <= last; b++) begin
         len = (b == last) ? stop_len : CPB;
         for (int k = 0; k < len; k++) begin
            @(negedge clk);
            rx_l[d] = bits[b];
            se_l[d] = (b == 0 && k == 0) ||
                      (inject && ((b == 3 && k == 5) || (b == last && k == 8)));
            if (b == 0 && k == 2) begin
               chk($sformatf("dut%0d_busy_start", d), busy_w[d], 1);
               chk($sformatf("dut%0d_data_held", d), data_w[d*8 +: 8], exp_data[d]);
               chk($sformatf("dut%0d_count_before", d), vcnt[d], vexp[d]);
            end
            if (rst_bit >= 0 && b == rst_bit + 1) begin
               if (k == 4) rst = 1'b1;
               if (k == 5) begin
                  rst = 1'b0;
                  chk($sformatf("dut%0d_busy_after_rst", d), busy_w[d], 0);
                  rx_l[d] = 1'b1;
                  se_l[d] = 1'b0;
                  clear_expect();
                  return;
               end
            end
            if (b == last && k == 9) chk($sformatf("dut%0d_valid_pulse", d), valid_w[d], 1);
            if (b == last && k == 10) begin
               chk($sformatf("dut%0d_valid_one_cycle", d), valid_w[d], 0);
               chk($sformatf("dut%0d_busy_after_stop", d), busy_w[d], 0);
            end
         end
      end
      rx_l[d] = 1'b1;
      se_l[d] = 1'b0;
      exp_data[d] = data;
      exp_pe[d]   = (d == 1) ? ((^data) ^ par) : 1'b0;
      exp_fe[d]   = ~stp;
      vexp[d]++;
      $display("frame dut%0d data=%02h par=%0d stop=%0d -> rx_data=%02h perr=%0d ferr=%0d",
               d, data, par, stp, data_w[d*8 +: 8], perr_w[d], ferr_w[d]);
      if (stop_len == CPB) chk_out(d);
   endtask

   task automatic false_start(input int d);
      for (int k = 0; k < CPB; k++) begin
         @(negedge clk);
         rx_l[d] = (k < 4) ? 1'b0 : 1'b1;
         se_l[d] = (k == 0);
         if (k == 8) chk("false_start_busy", busy_w[d], 1);
         if (k == 9) chk("false_start_idle", busy_w[d], 0);
      end
      se_l[d] = 1'b0;
      $display("false start dut%0d busy=%0d rx_data=%02h", d, busy_w[d], data_w[d*8 +: 8]);
      chk_out(d);
   endtask

   initial begin
      int          d;
      logic [7:0]  rd;
      logic        rp, rs;
      rst  = 1'b1;
      rx_l = 2'b11;
      se_l = 2'b00;
      clear_expect();
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("reset_rx_data", data_w[i*8 +: 8], 0);
         chk("reset_rx_valid", valid_w[i], 0);
         chk("reset_parity_err", perr_w[i], 0);
         chk("reset_frame_err", ferr_w[i], 0);
         chk("reset_busy", busy_w[i], 0);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b0, CPB, -1);
      send_frame(1, 8'h03, 1'b1, 1'b1, 1'b0, CPB, -1);
      send_frame(1, 8'h03, 1'b0, 1'b1, 1'b0, CPB, -1);
      send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0, CPB, -1);
      send_frame(0, 8'h11, 1'b0, 1'b1, 1'b0, CPB, -1);
      false_start(0);

      send_frame(0, 8'hFF, 1'b0, 1'b1, 1'b0, CPB, 3);
      repeat (20) @(negedge clk);
      chk_out(0);
      chk_out(1);
      send_frame(0, 8'h42, 1'b0, 1'b1, 1'b0, CPB, -1);

      // Back-to-back: the second start_edge lands on the first cycle back in IDLE.
      send_frame(0, 8'h01, 1'b0, 1'b1, 1'b1, 9, -1);
      send_frame(0, 8'h80, 1'b0, 1'b1, 1'b1, CPB, -1);

      for (int n = 0; n < 10; n++) begin
         d  = int'($urandom_range(0, 1));
         rd = 8'($urandom);
         rp = 1'($urandom);
         rs = ($urandom_range(0, 3) != 0);
         send_frame(d, rd, rp, rs, 1'($urandom), CPB, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
